eb_fifo: RTL and testbench

EB_FIFO -- requirements
Module: eb_fifo

---
 rtl/eb_pkg.sv | 15 +
 rtl/eb_fifo_ctrl.sv | 72 +++++++
 rtl/eb_fifo.sv | 52 +++++
 tb/tb_eb_fifo.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/eb_pkg.sv
// Shared constants and width helper for the elastic-buffer FIFO family.
package eb_pkg;

  localparam int EB_REG    = 0;
  localparam int EB_BYPASS = 1;

  // Ceiling log2 with a floor of 1, so a 1-bit pointer is still legal.
  function automatic int eb_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/eb_fifo_ctrl.sv
// Pointer, occupancy and full-flag control for eb_fifo; carries no payload.
module eb_fifo_ctrl
  import eb_pkg::*;
#(
  parameter  int DEPTH  = 2,
  parameter  int BYPASS = EB_REG,
  localparam int AW     = eb_clog2(DEPTH),
  localparam int CW     = eb_clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          t_0_valid,
  input  logic          i_0_ready,
  output logic          t_0_ready,
  output logic          i_0_valid,
  output logic          wr_en,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] level,
  output logic          pass
);

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          thru;
  logic          rd_en;
  logic [CW-1:0] level_nxt;

  assign empty     = (level == '0);
  assign pass      = (BYPASS == EB_BYPASS) && empty;
  // Ready comes straight from a flop: no comb path from i_0_ready.
  assign t_0_ready = ~full;
  assign i_0_valid = pass ? t_0_valid : ~empty;

  assign push  = t_0_valid & t_0_ready;
  assign pop   = i_0_valid & i_0_ready;
  // A word that flows straight through never touches the array.
  assign thru  = pass & push & i_0_ready;
  assign wr_en = push & ~thru;
  assign rd_en = pop & ~empty;

  always_comb begin
    level_nxt = level;
    case ({wr_en, rd_en})
      2'b10:   level_nxt = level + CW'(1);
      2'b01:   level_nxt = level - CW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == CW'(DEPTH));
    end
  end

  a_level_max: assert property (@(posedge clk) disable iff (!reset_n)
    level <= CW'(DEPTH));
  a_full_sync: assert property (@(posedge clk) disable iff (!reset_n)
    full == (level == CW'(DEPTH)));

endmodule

// File: rtl/eb_fifo.sv
// Elastic-buffer FIFO: registered-output or bypass mode around a small array.
module eb_fifo
  import eb_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 2,
  parameter  int BYPASS = EB_REG,
  localparam int AW     = eb_clog2(DEPTH),
  localparam int CW     = eb_clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] t_0_data,
  input  logic             t_0_valid,
  output logic             t_0_ready,
  output logic [WIDTH-1:0] i_0_data,
  output logic             i_0_valid,
  input  logic             i_0_ready,
  output logic [CW-1:0]    level
);

  logic             wr_en;
  logic             pass;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  eb_fifo_ctrl #(
    .DEPTH  (DEPTH),
    .BYPASS (BYPASS)
  ) u_ctrl (
    .clk       (clk),
    .reset_n   (reset_n),
    .t_0_valid (t_0_valid),
    .i_0_ready (i_0_ready),
    .t_0_ready (t_0_ready),
    .i_0_valid (i_0_valid),
    .wr_en     (wr_en),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .level     (level),
    .pass      (pass)
  );

  // Storage is intentionally unreset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= t_0_data;
  end

  assign i_0_data = pass ? t_0_data : mem[rd_ptr];

endmodule

// File: tb/tb_eb_fifo.sv
// Scoreboard bench for eb_fifo: registered instance plus a bypass instance.
module tb_eb_fifo;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic [7:0] t_data = '0, i_data;
  logic       t_valid = 1'b0, t_ready, i_valid, i_ready = 1'b0;
  logic [2:0] level;

  logic [7:0] b_t_data = '0, b_i_data;
  logic       b_t_valid = 1'b0, b_t_ready, b_i_valid, b_i_ready = 1'b0;
  logic [2:0] b_level;

  int n_chk = 0;
  int n_err = 0;
  int n_pop = 0;
  logic [7:0] sb  [$];
  logic [7:0] sb1 [$];

  always #5 clk = ~clk;

  eb_fifo #(.WIDTH(8), .DEPTH(4), .BYPASS(0)) u_reg (
    .clk(clk), .reset_n(reset_n),
    .t_0_data(t_data), .t_0_valid(t_valid), .t_0_ready(t_ready),
    .i_0_data(i_data), .i_0_valid(i_valid), .i_0_ready(i_ready),
    .level(level)
  );

  eb_fifo #(.WIDTH(8), .DEPTH(4), .BYPASS(1)) u_byp (
    .clk(clk), .reset_n(reset_n),
    .t_0_data(b_t_data), .t_0_valid(b_t_valid), .t_0_ready(b_t_ready),
    .i_0_data(b_i_data), .i_0_valid(b_i_valid), .i_0_ready(b_i_ready),
    .level(b_level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshakes are sampled mid-cycle, ahead of the edge that commits them.
  always @(negedge clk) begin
    if (reset_n) begin
      if (t_valid && t_ready) sb.push_back(t_data);
      if (i_valid && i_ready) begin
        n_pop++;
        chk("sb_avail", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) chk("sb_data", 32'(i_data), 32'(sb.pop_front()));
      end
      if (b_t_valid && b_t_ready) sb1.push_back(b_t_data);
      if (b_i_valid && b_i_ready) begin
        chk("sb1_avail", 32'(sb1.size() > 0), 1);
        if (sb1.size() > 0) chk("sb1_data", 32'(b_i_data), 32'(sb1.pop_front()));
      end
    end
  end

  initial begin
    int base;

    // Reset state
    #3;
    chk("rst_level", 32'(level), 0);
    chk("rst_ivalid", 32'(i_valid), 0);
    chk("rst_tready", 32'(t_ready), 1);
    chk("rst_b_level", 32'(b_level), 0);
    step();
    reset_n = 1'b1;
    step();

    // Fill to capacity with the sink stalled; the fifth word must bounce.
    i_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      t_valid = 1'b1;
      t_data  = 8'((k + 1) * 8'h11);
      step();
    end
    chk("fill_level", 32'(level), 4);
    chk("fill_tready", 32'(t_ready), 0);
    t_data = 8'h55;
    step();
    chk("fill_refuse_level", 32'(level), 4);
    t_valid = 1'b0;

    // Drain on consecutive cycles
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", 32'(i_valid), 1);
      chk("drain_data", 32'(i_data), 32'((k + 1) * 8'h11));
      step();
    end
    chk("drain_ivalid", 32'(i_valid), 0);
    chk("drain_level", 32'(level), 0);
    i_ready = 1'b0;

    // Full with simultaneous pop: push refused, ready returns next cycle
    for (int k = 0; k < 4; k++) begin
      t_valid = 1'b1;
      t_data  = 8'(8'hA1 + k);
      step();
    end
    chk("fp_level", 32'(level), 4);
    t_data  = 8'h5A;
    i_ready = 1'b1;
    chk("fp_tready_lo", 32'(t_ready), 0);
    step();
    t_valid = 1'b0;
    chk("fp_level3", 32'(level), 3);
    chk("fp_tready_hi", 32'(t_ready), 1);
    repeat (3) step();
    chk("fp_empty", 32'(level), 0);
    i_ready = 1'b0;

    // Streaming: one transfer per cycle, level pinned at 1
    base = n_pop;
    i_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      t_valid = 1'b1;
      t_data  = 8'(k);
      step();
      chk("stream_level", 32'(level), 1);
    end
    t_valid = 1'b0;
    step();
    chk("stream_tail_level", 32'(level), 0);
    chk("stream_count", 32'(n_pop - base), 100);
    i_ready = 1'b0;

    // Bypass: same-cycle pass-through leaves the array untouched
    b_t_valid = 1'b1;
    b_t_data  = 8'hA5;
    b_i_ready = 1'b1;
    #1;
    chk("byp_ivalid", 32'(b_i_valid), 1);
    chk("byp_idata", 32'(b_i_data), 32'h A5);
    chk("byp_level0", 32'(b_level), 0);
    step();
    chk("byp_level_after", 32'(b_level), 0);
    // Bypass instance stalled: the word is stored and held stable
    b_t_data  = 8'hB6;
    b_i_ready = 1'b0;
    step();
    b_t_valid = 1'b0;
    b_t_data  = 8'hC7;
    #1;
    chk("byp_store_level", 32'(b_level), 1);
    chk("byp_hold_data", 32'(b_i_data), 32'h B6);
    step();
    chk("byp_hold_data2", 32'(b_i_data), 32'h B6);
    b_i_ready = 1'b1;
    step();
    chk("byp_drained", 32'(b_level), 0);
    b_i_ready = 1'b0;

    // Reset mid-operation, asserted between edges
    for (int k = 0; k < 3; k++) begin
      t_valid = 1'b1;
      t_data  = 8'(8'h71 + k);
      step();
    end
    t_valid = 1'b0;
    chk("mid_level3", 32'(level), 3);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_ivalid", 32'(i_valid), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_tready", 32'(t_ready), 1);
    sb.delete();
    sb1.delete();
    reset_n = 1'b1;
    i_ready = 1'b1;
    repeat (3) begin
      step();
      chk("post_rst_ivalid", 32'(i_valid), 0);
    end
    i_ready = 1'b0;

    step();
    chk("sb_left", 32'(sb.size()), 0);
    chk("sb1_left", 32'(sb1.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
